// File: rtl/traffic_pkg.sv
// Shared light-code constants, single-light bit positions and the lamp driver FSM states.
package traffic_pkg;

    localparam logic [1:0] LIGHT_RED    = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_GREEN  = 2'b10;
    localparam logic [1:0] LIGHT_FLASH  = 2'b11;

    localparam int SL_WALK_TV  = 0;
    localparam int SL_WALK_NN  = 1;
    localparam int SL_WALK_NS  = 2;
    localparam int SL_ARROW_TV = 3;
    localparam int SL_ARROW_NN = 4;
    localparam int SL_ARROW_NS = 5;

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_FILTER  = 2'd1,
        ST_FAULT   = 2'd2,
        ST_RECOVER = 2'd3
    } drv_state_t;

    // Head code to {green, yellow, red}; flashing yellow follows the blink phase.
    function automatic logic [2:0] decode_head(input logic [1:0] code, input logic blink_on);
        logic [2:0] lamps;
        lamps = 3'b001;
        case (code)
            LIGHT_RED:    lamps = 3'b001;
            LIGHT_YELLOW: lamps = 3'b010;
            LIGHT_GREEN:  lamps = 3'b100;
            LIGHT_FLASH:  lamps = {1'b0, blink_on, 1'b0};
            default:      lamps = 3'b001;
        endcase
        return lamps;
    endfunction

endpackage

// File: rtl/lamp_safety_driver_if.sv
// Controller-command and lamp-pin bundle between the traffic controller and the lamp driver.
interface lamp_safety_driver_if;
    logic [1:0] lightNN;
    logic [1:0] lightNS;
    logic [1:0] lightTv;
    logic [5:0] singleLights;
    logic       clearFault;
    logic [2:0] lampsNN;
    logic [2:0] lampsNS;
    logic [2:0] lampsTv;
    logic [2:0] walkLamps;
    logic [2:0] dontWalkLamps;
    logic [2:0] arrowLamps;
    logic       fault;
    logic [2:0] faultCode;

    modport master (
        output lightNN, lightNS, lightTv, singleLights, clearFault,
        input  lampsNN, lampsNS, lampsTv, walkLamps, dontWalkLamps, arrowLamps, fault, faultCode
    );

    modport slave (
        input  lightNN, lightNS, lightTv, singleLights, clearFault,
        output lampsNN, lampsNS, lampsTv, walkLamps, dontWalkLamps, arrowLamps, fault, faultCode
    );
endinterface

// File: rtl/blink_gen.sv
// Free-running blink phase: blinkOn toggles every BLINK_HALF cycles, starting high out of reset.
module blink_gen #(
    parameter int unsigned BLINK_HALF = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic blinkOn
);
    localparam int CW = $clog2(BLINK_HALF - 1) + 1;

    logic [CW-1:0] r_blinkCnt;
    logic          r_blinkOn;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blinkCnt <= '0;
            r_blinkOn  <= 1'b1;
        end else if (r_blinkCnt == CW'(BLINK_HALF - 1)) begin
            r_blinkCnt <= '0;
            r_blinkOn  <= ~r_blinkOn;
        end else begin
            r_blinkCnt <= r_blinkCnt + 1'b1;
        end
    end

    assign blinkOn = r_blinkOn;
endmodule

// File: rtl/lamp_safety_driver.sv
// Lamp decoder with conflict monitor: persistent unsafe commands latch a flashing-yellow fault
// that only an operator clear (followed by an all-red hold) can release.
module lamp_safety_driver
    import traffic_pkg::*;
#(
    parameter int unsigned BLINK_HALF      = 25_000_000,
    parameter int unsigned CONFLICT_FILTER = 4,
    parameter int unsigned ALLRED_CYCLES   = 50_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    lamp_safety_driver_if.slave  bus
);
    localparam int FW = $clog2(CONFLICT_FILTER) + 1;
    localparam int AW = $clog2(ALLRED_CYCLES - 1) + 1;

    drv_state_t r_state, w_stateNxt;
    logic [FW-1:0] r_filterCnt, w_filterNxt, w_filterInc;
    logic [AW-1:0] r_allRedCnt, w_allRedNxt;
    logic [2:0]    r_codeAcc, w_codeAccNxt;
    logic [2:0]    r_faultCode, w_faultCodeNxt;
    logic [2:0]    w_c;
    logic          w_conf, w_blinkOn;
    logic          w_tvNotRed, w_nnGo, w_nsGo, w_tvGo;
    logic [2:0]    w_lampsNN, w_lampsNS, w_lampsTv, w_walk, w_dontWalk, w_arrow;
    logic          w_fault;
    logic [2:0]    r_lampsNN, r_lampsNS, r_lampsTv, r_walk, r_dontWalk, r_arrow;
    logic          r_fault;

    blink_gen #(.BLINK_HALF(BLINK_HALF)) u_blink (
        .clk     (clk),
        .reset   (reset),
        .blinkOn (w_blinkOn)
    );

    // "Go" means green or yellow; flashing yellow only matters through the not-red test.
    assign w_tvNotRed = (bus.lightTv != LIGHT_RED);
    assign w_tvGo     = (bus.lightTv == LIGHT_GREEN) || (bus.lightTv == LIGHT_YELLOW);
    assign w_nnGo     = (bus.lightNN == LIGHT_GREEN) || (bus.lightNN == LIGHT_YELLOW);
    assign w_nsGo     = (bus.lightNS == LIGHT_GREEN) || (bus.lightNS == LIGHT_YELLOW);

    assign w_c[0] = w_tvNotRed && ((bus.lightNN != LIGHT_RED) || (bus.lightNS != LIGHT_RED));
    assign w_c[1] = (bus.singleLights[SL_WALK_TV] && w_tvGo)
                 || (bus.singleLights[SL_WALK_NN] && (w_nnGo || w_tvNotRed))
                 || (bus.singleLights[SL_WALK_NS] && (w_nsGo || w_tvNotRed));
    assign w_c[2] = (bus.singleLights[SL_ARROW_TV]
                     && ((bus.lightNN == LIGHT_GREEN) || (bus.lightNS == LIGHT_GREEN)))
                 || ((bus.singleLights[SL_ARROW_NN] || bus.singleLights[SL_ARROW_NS])
                     && (bus.lightTv == LIGHT_GREEN));
    assign w_conf = |w_c;
    assign w_filterInc = r_filterCnt + 1'b1;

    always_comb begin
        w_stateNxt     = r_state;
        w_filterNxt    = r_filterCnt;
        w_allRedNxt    = r_allRedCnt;
        w_codeAccNxt   = r_codeAcc;
        w_faultCodeNxt = r_faultCode;
        case (r_state)
            ST_NORMAL: begin
                if (w_conf) begin
                    if (CONFLICT_FILTER <= 1) begin
                        w_stateNxt     = ST_FAULT;
                        w_faultCodeNxt = w_c;
                    end else begin
                        w_stateNxt   = ST_FILTER;
                        w_filterNxt  = FW'(1);
                        w_codeAccNxt = w_c;
                    end
                end
            end
            ST_FILTER: begin
                if (!w_conf) begin
                    w_stateNxt   = ST_NORMAL;
                    w_filterNxt  = '0;
                    w_codeAccNxt = '0;
                end else if (w_filterInc == FW'(CONFLICT_FILTER)) begin
                    w_stateNxt     = ST_FAULT;
                    w_filterNxt    = '0;
                    w_codeAccNxt   = '0;
                    w_faultCodeNxt = r_codeAcc | w_c;
                end else begin
                    w_filterNxt  = w_filterInc;
                    w_codeAccNxt = r_codeAcc | w_c;
                end
            end
            ST_FAULT: begin
                if (bus.clearFault && !w_conf) begin
                    w_stateNxt  = ST_RECOVER;
                    w_allRedNxt = '0;
                end
            end
            ST_RECOVER: begin
                if (w_conf) begin
                    w_stateNxt     = ST_FAULT;
                    w_faultCodeNxt = r_faultCode | w_c;
                end else if (r_allRedCnt == AW'(ALLRED_CYCLES - 1)) begin
                    w_stateNxt     = ST_NORMAL;
                    w_allRedNxt    = '0;
                    w_faultCodeNxt = '0;
                end else begin
                    w_allRedNxt = r_allRedCnt + 1'b1;
                end
            end
            default: w_stateNxt = ST_NORMAL;
        endcase
    end

    // Lamp image follows the state being entered so the pins change together with the state.
    always_comb begin
        w_lampsNN  = 3'b001;
        w_lampsNS  = 3'b001;
        w_lampsTv  = 3'b001;
        w_walk     = 3'b000;
        w_dontWalk = 3'b111;
        w_arrow    = 3'b000;
        w_fault    = 1'b0;
        case (w_stateNxt)
            ST_NORMAL, ST_FILTER: begin
                w_lampsNN  = decode_head(bus.lightNN, w_blinkOn);
                w_lampsNS  = decode_head(bus.lightNS, w_blinkOn);
                w_lampsTv  = decode_head(bus.lightTv, w_blinkOn);
                w_walk     = bus.singleLights[SL_WALK_NS:SL_WALK_TV];
                w_dontWalk = ~bus.singleLights[SL_WALK_NS:SL_WALK_TV];
                w_arrow    = bus.singleLights[SL_ARROW_NS:SL_ARROW_TV];
            end
            ST_FAULT: begin
                w_lampsNN = {1'b0, w_blinkOn, 1'b0};
                w_lampsNS = {1'b0, w_blinkOn, 1'b0};
                w_lampsTv = {1'b0, w_blinkOn, 1'b0};
                w_fault   = 1'b1;
            end
            default: w_fault = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_NORMAL;
            r_filterCnt <= '0;
            r_allRedCnt <= '0;
            r_codeAcc   <= '0;
            r_faultCode <= '0;
            r_lampsNN   <= 3'b001;
            r_lampsNS   <= 3'b001;
            r_lampsTv   <= 3'b001;
            r_walk      <= 3'b000;
            r_dontWalk  <= 3'b111;
            r_arrow     <= 3'b000;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_stateNxt;
            r_filterCnt <= w_filterNxt;
            r_allRedCnt <= w_allRedNxt;
            r_codeAcc   <= w_codeAccNxt;
            r_faultCode <= w_faultCodeNxt;
            r_lampsNN   <= w_lampsNN;
            r_lampsNS   <= w_lampsNS;
            r_lampsTv   <= w_lampsTv;
            r_walk      <= w_walk;
            r_dontWalk  <= w_dontWalk;
            r_arrow     <= w_arrow;
            r_fault     <= w_fault;
        end
    end

    assign bus.lampsNN       = r_lampsNN;
    assign bus.lampsNS       = r_lampsNS;
    assign bus.lampsTv       = r_lampsTv;
    assign bus.walkLamps     = r_walk;
    assign bus.dontWalkLamps = r_dontWalk;
    assign bus.arrowLamps    = r_arrow;
    assign bus.fault         = r_fault;
    assign bus.faultCode     = r_faultCode;
endmodule

// File: tb/tb_lamp_safety_driver.sv
// Directed scoreboard bench for lamp_safety_driver: each stimulus cycle queues the expected lamp
// image, and a monitor compares it one cycle later.
module tb_lamp_safety_driver;
    localparam int BH = 4;
    localparam int CF = 4;
    localparam int AR = 6;
    localparam int M_NORM = 0;
    localparam int M_FAULT = 1;
    localparam int M_REC = 2;

    typedef struct {
        string       name;
        logic [21:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    logic          tb_blink;
    int            tb_bcnt;

    lamp_safety_driver_if bus();

    lamp_safety_driver #(
        .BLINK_HALF      (BH),
        .CONFLICT_FILTER (CF),
        .ALLRED_CYCLES   (AR)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference blink phase: high out of reset, toggles after every BH cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tb_blink <= 1'b1;
            tb_bcnt  <= 0;
        end else if (tb_bcnt == BH - 1) begin
            tb_bcnt  <= 0;
            tb_blink <= ~tb_blink;
        end else begin
            tb_bcnt <= tb_bcnt + 1;
        end
    end

    function automatic logic [2:0] head(input logic [1:0] code, input logic blink);
        case (code)
            2'b00:   return 3'b001;
            2'b01:   return 3'b010;
            2'b10:   return 3'b100;
            default: return {1'b0, blink, 1'b0};
        endcase
    endfunction

    function automatic logic [21:0] actual();
        return {bus.lampsTv, bus.lampsNN, bus.lampsNS, bus.walkLamps, bus.dontWalkLamps,
                bus.arrowLamps, bus.fault, bus.faultCode};
    endfunction

    task automatic check(input string name, input logic [21:0] got, input logic [21:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h (Tv,NN,NS,walk,dw,arrow,fault,code) expected %h", name, got, exp);
        end
    endtask

    // Drive one cycle of controller commands and queue the lamp image it must produce.
    task automatic step(input string name, input logic [1:0] tv, input logic [1:0] nn,
                        input logic [1:0] ns, input logic [5:0] sl, input logic clr,
                        input int mode, input logic [2:0] fc);
        exp_t e;
        @(negedge clk);
        bus.lightTv      = tv;
        bus.lightNN      = nn;
        bus.lightNS      = ns;
        bus.singleLights = sl;
        bus.clearFault   = clr;
        e.name = name;
        if (mode == M_NORM)
            e.exp = {head(tv, tb_blink), head(nn, tb_blink), head(ns, tb_blink),
                     sl[2:0], ~sl[2:0], sl[5:3], 1'b0, fc};
        else if (mode == M_FAULT)
            e.exp = {{3{1'b0, tb_blink, 1'b0}}, 3'b000, 3'b111, 3'b000, 1'b1, fc};
        else
            e.exp = {9'b001_001_001, 3'b000, 3'b111, 3'b000, 1'b1, fc};
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.name, actual(), e.exp);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    localparam logic [21:0] RESET_IMG = {9'b001_001_001, 3'b000, 3'b111, 3'b000, 1'b0, 3'b000};

    initial begin : driver
        bus.lightTv = 2'b00; bus.lightNN = 2'b00; bus.lightNS = 2'b00;
        bus.singleLights = 6'b0; bus.clearFault = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_values", actual(), RESET_IMG);
        rst = 1'b0;

        step("decode_tv_green_walks", 2'b10, 2'b00, 2'b00, 6'b000110, 1'b0, M_NORM, 3'b000);
        step("decode_all_red", 2'b00, 2'b00, 2'b00, 6'b000000, 1'b0, M_NORM, 3'b000);
        for (int i = 0; i < 10; i++)
            step("blink_nn_flash", 2'b00, 2'b11, 2'b00, 6'b000000, 1'b0, M_NORM, 3'b000);
        step("arrows_safe", 2'b00, 2'b10, 2'b00, 6'b010000, 1'b0, M_NORM, 3'b000);

        for (int i = 0; i < 3; i++)
            step("filter_short_conflict", 2'b10, 2'b10, 2'b00, 6'b0, 1'b0, M_NORM, 3'b000);
        step("filter_abort", 2'b00, 2'b10, 2'b00, 6'b0, 1'b0, M_NORM, 3'b000);
        step("filter_back_normal", 2'b00, 2'b00, 2'b00, 6'b0, 1'b0, M_NORM, 3'b000);

        for (int i = 0; i < 3; i++)
            step("filter_window", 2'b10, 2'b10, 2'b00, 6'b0, 1'b0, M_NORM, 3'b000);
        step("fault_entry_crossing", 2'b10, 2'b10, 2'b00, 6'b0, 1'b0, M_FAULT, 3'b001);
        for (int i = 0; i < 2; i++)
            step("clear_ignored_in_conflict", 2'b10, 2'b10, 2'b00, 6'b0, 1'b1, M_FAULT, 3'b001);
        step("fault_hold_no_clear", 2'b00, 2'b00, 2'b00, 6'b0, 1'b0, M_FAULT, 3'b001);
        step("recover_entry", 2'b00, 2'b00, 2'b00, 6'b0, 1'b1, M_REC, 3'b001);
        for (int i = 0; i < AR - 1; i++)
            step("recover_all_red", 2'b00, 2'b00, 2'b00, 6'b0, 1'b0, M_REC, 3'b001);
        step("recover_to_normal", 2'b00, 2'b00, 2'b00, 6'b0, 1'b0, M_NORM, 3'b000);

        for (int i = 0; i < 3; i++)
            step("walk_vs_yellow_window", 2'b01, 2'b00, 2'b00, 6'b000010, 1'b0, M_NORM, 3'b000);
        step("fault_entry_walk", 2'b01, 2'b00, 2'b00, 6'b000010, 1'b0, M_FAULT, 3'b010);
        step("fault_hold_walk", 2'b01, 2'b00, 2'b00, 6'b000010, 1'b0, M_FAULT, 3'b010);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d pending, required 0", exp_q.size());
        end
        rst = 1'b1;
        #1;
        check("async_reset_mid_fault", actual(), RESET_IMG);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lamp_safety_driver.md
# lamp_safety_driver

Decodes the light commands produced by the traffic controller state machine (three 2-bit head codes plus the 6-bit single-light vector) into individual lamp drive lines for the Thevenin and Norton intersection. It also enforces a hardware conflict monitor: a persistent unsafe command combination forces every head to flashing yellow until an operator clears the fault. It sits between the controller outputs and the physical lamp pins.

## Interface
- BLINK_HALF, default 25_000_000: clock cycles per blink half-period (on phase or off phase).
- CONFLICT_FILTER, default 4: consecutive cycles a conflict must persist before the fault latches; minimum 1.
- ALLRED_CYCLES, default 50_000_000: all-red hold after a fault clears, before normal decoding resumes.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- lightNN, lightNS, lightTv  in  2 each  head codes: 00 red, 01 yellow, 10 green, 11 flashing yellow.
- singleLights  in  6  [0] walk Tv, [1] walk NN, [2] walk NS, [3] arrow Tv, [4] arrow NN, [5] arrow NS.
- clearFault  in  1  operator fault clear, level-sampled each cycle.
- lampsNN, lampsNS, lampsTv  out  3 each  {green, yellow, red} lamp drives.
- walkLamps  out  3  walk lamps, bit order Tv, NN, NS.
- dontWalkLamps  out  3  don't-walk lamps, same bit order.
- arrowLamps  out  3  arrow lamps, same bit order.
- fault  out  1  high in FAULT and RECOVER.
- faultCode  out  3  captured conflict cause: bit0 crossing heads, bit1 walk vs. green, bit2 arrow vs. opposing green.

## Operation
- The FSM has four states: NORMAL, FILTER, FAULT, RECOVER. Reset enters NORMAL.
- Conflict conditions are evaluated combinationally every cycle:
  - c0: lightTv is not red, and lightNN or lightNS is not red. Flashing yellow counts as not red.
  - c1: a walk bit is set while its own head is green or yellow. NN and NS walks also count against a non-red Tv.
  - c2: arrow Tv is set while NN or NS is green, or arrow NN/NS is set while Tv is green.
- NORMAL:
  - Decode the inputs.
  - Code 11 drives yellow gated by blinkOn.
  - Each dontWalk bit is the inverse of its walk bit.
  - Any conflict moves the FSM to FILTER with filterCnt=1.
- FILTER:
  - Keep decoding normally.
  - If the conflict is still present, increment filterCnt. When filterCnt reaches CONFLICT_FILTER, go to FAULT and latch faultCode as the OR of the c-bits seen during the filter window.
  - If the conflict is absent, return to NORMAL and clear filterCnt.
  - With CONFLICT_FILTER=1, FAULT is entered directly from NORMAL.
- FAULT:
  - All heads drive yellow=blinkOn, red=0, green=0.
  - Walk and arrow lamps are 0; dontWalk lamps are all 1.
  - If clearFault=1 and no conflict is present this cycle, go to RECOVER and load allRedCnt=0.
  - If clearFault=1 while a conflict is present, ignore it.
- RECOVER:
  - All heads red only, walks 0, dontWalk 1, arrows 0.
  - Increment allRedCnt. At ALLRED_CYCLES-1, go to NORMAL and clear faultCode.
  - A conflict during RECOVER returns to FAULT with faultCode |= the new c-bits.
- Blink generator:
  - blinkCnt counts 0..BLINK_HALF-1 and wraps.
  - blinkOn toggles on the wrap.
  - It runs free in every state; blinkOn resets to 1.
- Counter widths are $clog2 of their maximum value plus 1; no counter wraps except blinkCnt.

## Timing
- All outputs are registered, giving 1-cycle latency from inputs and state to the lamp pins.
- Reset values:
  - Every head drives {0,0,1} (red).
  - walkLamps=0, dontWalkLamps=3'b111, arrowLamps=0.
  - fault=0, faultCode=0.
  - blinkOn=1, blinkCnt=0, filterCnt=0, allRedCnt=0.
- Fault latency: a conflict first presented at cycle t asserts fault and the flashing outputs at cycle t+CONFLICT_FILTER.
- Input changes within the same cycle as the FILTER→FAULT decision use that cycle's conflict evaluation.
- Reset asserted mid-FAULT or mid-RECOVER returns immediately (asynchronously) to the reset values.

## Structure
- Shared package traffic_pkg holds:
  - light code constants: LIGHT_RED, LIGHT_YELLOW, LIGHT_GREEN, LIGHT_FLASH;
  - singleLights bit index constants;
  - the driver state enum.
- One natural sub-module, blink_gen: parameter BLINK_HALF; ports clk, reset, blinkOn.

## Test plan
- Reset, then lightTv=10, NN=00, NS=00, singleLights=6'b000110 → next cycle lampsTv=100, lampsNN=001, walkLamps=110, dontWalkLamps=001, fault=0.
- lightNN=11 with BLINK_HALF=4 → yellow NN toggles every 4 cycles, starting on; red and green stay 0.
- Tv=10 and NN=10 held 3 cycles, then Tv=00 (CONFLICT_FILTER=4) → fault never asserts and the FSM returns to NORMAL.
- Same conflict held 4 cycles → fault=1 on cycle 4 and faultCode=001; all heads flash yellow, dontWalkLamps=111.
- In FAULT, clearFault=1 with a conflict present → stays FAULT. Remove the conflict and pulse clearFault → ALLRED_CYCLES cycles of all-red with fault=1, then NORMAL and faultCode=0.
- Walk NN set with Tv=01 → faultCode=010 after the filter. Assert reset mid-FAULT → outputs at reset values within the same cycle.
